fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Controls the instruction fetch stage. It owns the program counter, addresses the instruction memory, and loads fetched words into the IF/ID register using a valid/ready handshake with decode. It also applies branch/jump redirects from later stages, flushing wrong-path instructions, and halts fetch on request. It sits between the instruction memory and the decode stage and replaces free-running PC increment with sequenced fetch.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- Clk  in  1  rising-edge clock.
- Reset  in  1  reset; synchronous and active-high.
- InstrIn  in  32  instruction memory read data for PCAddr; combinational, same cycle.
- BranchTaken  in  1  redirect request from execute; single-cycle pulse.
- BranchTarget  in  32  redirect address; bits [1:0] are forced to 0.
- Halt  in  1  stop fetching; sticky until Reset.
- DecReady  in  1  decode accepts IF/ID contents this cycle.
- PCAddr  out  32  current PC, driven to instruction memory.
- IFIDInstr  out  32  registered instruction to decode.
- IFIDPCPlus4  out  32  registered PC+4 of IFIDInstr.
- IFIDValid  out  1  IF/ID holds a valid instruction.
- Halted  out  1  FSM is in HALTED.

## Operation
- FSM states: BOOT, RUN, REDIRECT, HALTED.
- Reset (highest priority):
  - State = BOOT, PCAddr = RESET_PC.
  - IFIDInstr = 0, IFIDPCPlus4 = 0, IFIDValid = 0, Halted = 0.
- BOOT: no capture. Moves to RUN on the next edge.
- Transfer: a transfer occurs when IFIDValid && DecReady.
- Capture is allowed when !IFIDValid || DecReady.
- RUN, no redirect and no Halt, capture allowed:
  - IFIDInstr <= InstrIn, IFIDPCPlus4 <= PCAddr+4, IFIDValid <= 1.
  - PCAddr <= PCAddr+4.
- RUN, capture not allowed: PC and IF/ID hold (stall).
- RUN with BranchTaken (overrides Halt and capture):
  - PCAddr <= {BranchTarget[31:2],2'b00}, IFIDValid <= 0 (flush), state <= REDIRECT.
- REDIRECT: one bubble cycle; IFIDValid stays 0 and PC holds.
  - BranchTaken here retargets the PC and stays in REDIRECT.
  - Otherwise moves to RUN.
- RUN with Halt and no BranchTaken: state <= HALTED, Halted <= 1, no capture.
- HALTED:
  - PC frozen.
  - An IF/ID entry that is still valid is kept until transferred, then IFIDValid <= 0.
  - BranchTaken and Halt are ignored. Only Reset exits.
- Arithmetic: 32-bit modulo. 32'hFFFF_FFFC + 4 = 32'h0000_0000. No overflow flag.
- Simultaneous transfer and capture in the same cycle is back-to-back streaming: one instruction per cycle.

## Timing
- PCAddr is a register output; InstrIn must settle within the same cycle.
- Reset to first IFIDValid: 2 edges (BOOT, then the first RUN capture).
- Steady-state throughput: 1 instruction/cycle while DecReady = 1.
- BranchTaken at edge N:
  - Target is on PCAddr after N.
  - First target instruction is valid after edge N+2 (1 bubble).
- Stall: IF/ID outputs are stable for every cycle that IFIDValid && !DecReady.
- Reset mid-operation discards the IF/ID contents and any pending redirect on the next edge.

## Configuration
- FETCH_PERF_EN defined: adds two ports, both reset to 0 and wrapping at 2^32.
  - FetchCount out 32: number of transfers.
  - BubbleCount out 32: number of cycles in RUN/REDIRECT with IFIDValid = 0.
- FETCH_PERF_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Package fetch_pkg holds:
  - FSM state typedef: 2-bit encoding, BOOT=0, RUN=1, REDIRECT=2, HALTED=3.
  - Constants PC_STEP = 4 and DEFAULT_RESET_PC.
- One sub-module, fetch_pc_reg:
  - PC register with load (redirect), increment and hold controls, plus Reset to RESET_PC.
  - The top level holds the FSM, the IF/ID register and the optional counters.

## Test plan
- Reset held 3 cycles, then released, DecReady = 1, InstrIn = memory image (word at 0 = 32'h2010_0001):
  - IFIDValid rises after 2 edges with IFIDInstr = 32'h2010_0001, IFIDPCPlus4 = 4.
  - PCAddr then steps 8, 12, 16.
- DecReady = 0 for 4 cycles with IFIDValid = 1 (PC = 12):
  - PCAddr stays 12 and IF/ID is unchanged.
  - On release, the next instruction follows with no gap.
- BranchTaken pulse with BranchTarget = 32'h0000_0043:
  - PCAddr = 32'h40 next cycle, IFIDValid = 0 for 2 cycles.
  - Then IFIDPCPlus4 = 32'h44.
- RESET_PC = 32'hFFFF_FFF8, streaming: PCAddr sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Halt with IFIDValid = 1, DecReady = 0, with BranchTaken in the same cycle:
  - Redirect wins. Halt asserted again 2 cycles later sets Halted = 1.
  - The pending entry stays until DecReady = 1, then IFIDValid = 0 and PC is frozen.
- Reset mid-stream (PC = 32'h20, IFIDValid = 1):
  - Next edge gives PCAddr = RESET_PC, IFIDValid = 0, Halted = 0.
  - With FETCH_PERF_EN defined, FetchCount = 0 and BubbleCount = 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// The optional FETCH_PERF_EN build adds transfer and bubble counters to fetch_sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    HALTED   = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with redirect load, sequential increment and hold.
// A redirect target is always word-aligned on load.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        load,
  input  logic [31:0] target,
  input  logic        incr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  assign pc_plus4 = pc + PC_STEP;

  always_ff @(posedge Clk) begin
    if (Reset)
      pc <= RESET_PC;
    else if (load)
      pc <= target & 32'hFFFF_FFFC;
    else if (incr)
      pc <= pc_plus4;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch stage sequencer: owns the PC, fills IF/ID under a valid/ready handshake,
// applies redirects and halts. Define FETCH_PERF_EN to add FetchCount/BubbleCount.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] InstrIn,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Halt,
  input  logic        DecReady,
  output logic [31:0] PCAddr,
  output logic [31:0] IFIDInstr,
  output logic [31:0] IFIDPCPlus4,
  output logic        IFIDValid,
  output logic        Halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount
`endif
);

  fetch_state_t state, state_next;
  logic         pc_load, capture, transfer, capture_ok;
  logic [31:0]  pc_plus4;

  assign transfer   = IFIDValid && DecReady;
  assign capture_ok = !IFIDValid || DecReady;
  assign Halted     = (state == HALTED);

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (pc_load),
    .target   (BranchTarget),
    .incr     (capture),
    .pc       (PCAddr),
    .pc_plus4 (pc_plus4)
  );

  always_ff @(posedge Clk) begin
    if (Reset)
      state <= BOOT;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:     state_next = RUN;
      RUN:      if (BranchTaken)   state_next = REDIRECT;
                else if (Halt)     state_next = HALTED;
      REDIRECT: state_next = BranchTaken ? REDIRECT : RUN;
      HALTED:   state_next = HALTED;
      default:  state_next = BOOT;
    endcase
  end

  // Redirect beats halt and capture; halted or booting states never capture.
  always_comb begin
    pc_load = 1'b0;
    capture = 1'b0;
    case (state)
      RUN: begin
        if (BranchTaken)
          pc_load = 1'b1;
        else if (!Halt && capture_ok)
          capture = 1'b1;
      end
      REDIRECT: pc_load = BranchTaken;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      IFIDInstr   <= 32'h0;
      IFIDPCPlus4 <= 32'h0;
      IFIDValid   <= 1'b0;
    end else if (pc_load) begin
      IFIDValid <= 1'b0;
    end else if (capture) begin
      IFIDInstr   <= InstrIn;
      IFIDPCPlus4 <= pc_plus4;
      IFIDValid   <= 1'b1;
    end else if (transfer) begin
      IFIDValid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      FetchCount  <= 32'h0;
      BubbleCount <= 32'h0;
    end else begin
      if (transfer)
        FetchCount <= FetchCount + 32'd1;
      if ((state == RUN || state == REDIRECT) && !IFIDValid)
        BubbleCount <= BubbleCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table for reset/stream/stall/redirect,
// plus hand sequences for halt, PC wrap-around and reset mid-stream.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk;
  logic        reset, branch, halt, decready;
  logic [31:0] target;
  logic [31:0] instr1, pc1, ifinstr1, ifp41;
  logic        valid1, halted1;
  logic [31:0] instr2, pc2, ifinstr2, ifp42;
  logic        valid2, halted2;
`ifdef FETCH_PERF_EN
  logic [31:0] fc1, bc1, fc2, bc2;
`endif

  int total = 0;
  int bad = 0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2010_0001 : (32'h1300_0000 ^ a);
  endfunction

  assign instr1 = memword(pc1);
  assign instr2 = memword(pc2);

  fetch_sequencer dut (
    .Clk(clk), .Reset(reset), .InstrIn(instr1), .BranchTaken(branch),
    .BranchTarget(target), .Halt(halt), .DecReady(decready),
    .PCAddr(pc1), .IFIDInstr(ifinstr1), .IFIDPCPlus4(ifp41),
    .IFIDValid(valid1), .Halted(halted1)
`ifdef FETCH_PERF_EN
    , .FetchCount(fc1), .BubbleCount(bc1)
`endif
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .Clk(clk), .Reset(reset), .InstrIn(instr2), .BranchTaken(branch),
    .BranchTarget(target), .Halt(halt), .DecReady(decready),
    .PCAddr(pc2), .IFIDInstr(ifinstr2), .IFIDPCPlus4(ifp42),
    .IFIDValid(valid2), .Halted(halted2)
`ifdef FETCH_PERF_EN
    , .FetchCount(fc2), .BubbleCount(bc2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst, br, hlt, dr;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] instr, p4;
    logic        halted;
  } vec_t;

  function automatic vec_t mk(input logic rst, br, hlt, dr, input logic [31:0] tgt,
                              input logic [31:0] pc, input logic valid,
                              input logic [31:0] instr, p4, input logic halted);
    vec_t v;
    v.rst = rst; v.br = br; v.hlt = hlt; v.dr = dr; v.tgt = tgt;
    v.pc = pc; v.valid = valid; v.instr = instr; v.p4 = p4; v.halted = halted;
    return v;
  endfunction

  task automatic applyStimulus(input logic rst, br, hlt, dr, input logic [31:0] tgt);
    reset = rst; branch = br; halt = hlt; decready = dr; target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  vec_t vecs[17];

  initial begin
    reset = 1'b1; branch = 1'b0; halt = 1'b0; decready = 1'b1; target = 32'h0;

    // Reset, boot, stream, 4-cycle stall, redirect to 0x43 -> 0x40.
    vecs[0]  = mk(1,0,0,1, 0,     32'h0,  0, 0, 0, 0);
    vecs[1]  = mk(1,0,0,1, 0,     32'h0,  0, 0, 0, 0);
    vecs[2]  = mk(1,0,0,1, 0,     32'h0,  0, 0, 0, 0);
    vecs[3]  = mk(0,0,0,1, 0,     32'h0,  0, 0, 0, 0);
    vecs[4]  = mk(0,0,0,1, 0,     32'h4,  1, 32'h2010_0001, 32'h4, 0);
    vecs[5]  = mk(0,0,0,1, 0,     32'h8,  1, 32'h1300_0004, 32'h8, 0);
    vecs[6]  = mk(0,0,0,1, 0,     32'hC,  1, 32'h1300_0008, 32'hC, 0);
    vecs[7]  = mk(0,0,0,0, 0,     32'hC,  1, 32'h1300_0008, 32'hC, 0);
    vecs[8]  = mk(0,0,0,0, 0,     32'hC,  1, 32'h1300_0008, 32'hC, 0);
    vecs[9]  = mk(0,0,0,0, 0,     32'hC,  1, 32'h1300_0008, 32'hC, 0);
    vecs[10] = mk(0,0,0,0, 0,     32'hC,  1, 32'h1300_0008, 32'hC, 0);
    vecs[11] = mk(0,0,0,1, 0,     32'h10, 1, 32'h1300_000C, 32'h10, 0);
    vecs[12] = mk(0,0,0,1, 0,     32'h14, 1, 32'h1300_0010, 32'h14, 0);
    vecs[13] = mk(0,1,0,1, 32'h43, 32'h40, 0, 0, 0, 0);
    vecs[14] = mk(0,0,0,1, 0,     32'h40, 0, 0, 0, 0);
    vecs[15] = mk(0,0,0,1, 0,     32'h44, 1, 32'h1300_0040, 32'h44, 0);
    vecs[16] = mk(0,0,0,1, 0,     32'h48, 1, 32'h1300_0044, 32'h48, 0);

    #1;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].br, vecs[i].hlt, vecs[i].dr, vecs[i].tgt);
      checkOutput($sformatf("vec%0d pc", i), pc1, vecs[i].pc);
      checkOutput($sformatf("vec%0d valid", i), {31'h0, valid1}, {31'h0, vecs[i].valid});
      checkOutput($sformatf("vec%0d halted", i), {31'h0, halted1}, {31'h0, vecs[i].halted});
      if (vecs[i].valid || vecs[i].rst) begin
        checkOutput($sformatf("vec%0d instr", i), ifinstr1, vecs[i].instr);
        checkOutput($sformatf("vec%0d pcplus4", i), ifp41, vecs[i].p4);
      end
    end

    // Halt with a pending entry and a redirect in the same cycle: redirect wins.
    applyStimulus(0, 1, 1, 0, 32'h80);
    checkOutput("halt_br pc", pc1, 32'h80);
    checkOutput("halt_br valid", {31'h0, valid1}, 32'h0);
    checkOutput("halt_br halted", {31'h0, halted1}, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkOutput("bubble pc", pc1, 32'h80);
    checkOutput("bubble valid", {31'h0, valid1}, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkOutput("refill pc", pc1, 32'h84);
    checkOutput("refill instr", ifinstr1, memword(32'h80));
    checkOutput("refill valid", {31'h0, valid1}, 32'h1);
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("halt pc", pc1, 32'h84);
    checkOutput("halt halted", {31'h0, halted1}, 32'h1);
    checkOutput("halt valid kept", {31'h0, valid1}, 32'h1);
    applyStimulus(0, 1, 1, 0, 32'h100);
    checkOutput("halted ignore br pc", pc1, 32'h84);
    checkOutput("halted keep instr", ifinstr1, memword(32'h80));
    checkOutput("halted keep valid", {31'h0, valid1}, 32'h1);
    applyStimulus(0, 0, 1, 1, 32'h0);
    checkOutput("halted drain valid", {31'h0, valid1}, 32'h0);
    checkOutput("halted drain pc", pc1, 32'h84);
    applyStimulus(0, 0, 1, 1, 32'h0);
    checkOutput("halted frozen pc", pc1, 32'h84);
    checkOutput("halted stays", {31'h0, halted1}, 32'h1);

    // Reset exits HALTED; second instance streams across the 32-bit wrap.
    applyStimulus(1, 0, 0, 1, 32'h0);
    checkOutput("rst pc", pc1, 32'h0);
    checkOutput("rst halted", {31'h0, halted1}, 32'h0);
    checkOutput("rst valid", {31'h0, valid1}, 32'h0);
    checkOutput("wrap rst pc", pc2, 32'hFFFF_FFF8);
    checkOutput("wrap rst halted", {31'h0, halted2}, 32'h0);
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(0, 0, 0, 1, 32'h0);
      if (k <= 4)
        checkOutput($sformatf("wrap pc k%0d", k), pc2, 32'hFFFF_FFF8 + 32'd4 * (k - 1));
      if (k == 2) begin
        checkOutput("wrap valid", {31'h0, valid2}, 32'h1);
        checkOutput("wrap instr", ifinstr2, memword(32'hFFFF_FFF8));
      end
      if (k == 3)
        checkOutput("wrap pcplus4", ifp42, 32'h0);
    end
    checkOutput("mid pc", pc1, 32'h20);
    checkOutput("mid valid", {31'h0, valid1}, 32'h1);
`ifdef FETCH_PERF_EN
    checkOutput("mid fetchcount", fc1, 32'd7);
    checkOutput("mid bubblecount", bc1, 32'd1);
    checkOutput("wrap fetchcount", fc2, 32'd7);
    checkOutput("wrap bubblecount", bc2, 32'd1);
`endif
    applyStimulus(1, 0, 0, 1, 32'h0);
    checkOutput("midrst pc", pc1, 32'h0);
    checkOutput("midrst valid", {31'h0, valid1}, 32'h0);
    checkOutput("midrst halted", {31'h0, halted1}, 32'h0);
`ifdef FETCH_PERF_EN
    checkOutput("midrst fetchcount", fc1, 32'd0);
    checkOutput("midrst bubblecount", bc1, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
